// File: rtl/uart_tx_drain.sv
// UART transmitter that drains an upstream show-ahead FIFO, one frame per entry.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line high; pops the FIFO head as soon as it is non-empty
// S_START | start bit (tx low) for CLKS_PER_BIT cycles
// S_DATA  | DATA_WIDTH payload bits, LSB first
// S_PARITY| even parity of the latched word (UART_TX_PARITY_EN only)
// S_STOP  | stop bit (tx high), then back to S_IDLE
module uart_tx_drain #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   output logic                  tx,
   output logic                  busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic [BW-1:0]         bit_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  tx_q;
   logic                  busy_q;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q;
`endif

   logic bit_end;
   assign bit_end = (cnt_q == CNT_LAST);

   // Pop is combinational so the head word is captured on the same edge it is
   // released; gating with resetn keeps the strobe low while held in reset.
   assign fifo_pop = resetn & (state_q == S_IDLE) & ~fifo_empty;
   assign tx       = tx_q;
   assign busy     = busy_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               bit_q <= '0;
               if (!fifo_empty) begin
                  shift_q  <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^fifo_dout;
`endif
                  tx_q     <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= S_START;
               end
            end

            S_START: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  state_q <= S_DATA;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            S_DATA: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (bit_q == BIT_LAST) begin
                     bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                     tx_q    <= parity_q;
                     state_q <= S_PARITY;
`else
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
`endif
                  end else begin
                     bit_q   <= bit_q + BW'(1);
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  tx_q    <= 1'b1;
                  state_q <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
`endif

            S_STOP: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               bit_q   <= '0;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
